srio_link_monitor: RTL and testbench
====================================

# srio_link_monitor

Link supervisor in the cfg_clk domain that acts as the requesting side of the SRIO reset controller's reinitialization handshake. It watches the asynchronous port_initialized status, raises force_reinit when training exceeds a timeout or software asks for it, and holds the request until the reset controller acknowledges it via controlled_force_reinit. It then waits to be reset by the resulting PHY reset. If that reset never arrives, it aborts and backs off.

## Interface
- TIMEOUT_CYCLES, 24'd1_000_000: cfg_clk cycles port_initialized may stay low before an automatic reinit request; must be ≥2.
- ACK_TIMEOUT, 16'd4096: cfg_clk cycles a request may stay unacknowledged or unresolved before abort; must be ≥2.
- HOLDOFF_CYCLES, 16'd1024: back-off after an abort before monitoring resumes; must be ≥2.
- cfg_clk  in  1  clock.
- reset_condition  in  1  reset, asynchronous, active-high; clock cfg_clk.
- port_initialized  in  1  PHY port status, asynchronous to cfg_clk.
- controlled_force_reinit  in  1  acknowledge from the reset controller (log_clk domain), asynchronous.
- monitor_en  in  1  enables the automatic timeout; synchronous to cfg_clk.
- user_reinit_req  in  1  single-cycle software reinit request, synchronous to cfg_clk.
- force_reinit  out  1  registered reinit request to the reset controller.
- link_up  out  1  registered; high while in LINK_UP.
- timeout_evt  out  1  one-cycle pulse when the training timeout fires.
- link_down_evt  out  1  one-cycle pulse on LINK_UP→WAIT_INIT.
- ack_timeout_evt  out  1  one-cycle pulse on an abort into HOLDOFF.

## Operation
- Synchronizers: port_initialized and controlled_force_reinit each pass through 2-FF synchronizers, giving pi_s and ack_s. Both synchronizers reset to 0.
- Timer: a single 24-bit counter. It clears on every state change and increments otherwise. It is held at 0 in WAIT_INIT while monitor_en=0 and in LINK_UP.
- States: WAIT_INIT, LINK_UP, REQUEST, ACKED, HOLDOFF. Reset state is WAIT_INIT.
- WAIT_INIT:
  - pi_s=1 → LINK_UP.
  - Otherwise, user_reinit_req → REQUEST.
  - Otherwise, monitor_en=1 and timer==TIMEOUT_CYCLES-1 → REQUEST, with timeout_evt.
  - If user_reinit_req and the timeout coincide, go to REQUEST and still pulse timeout_evt.
- LINK_UP:
  - pi_s=0 → WAIT_INIT, with link_down_evt.
  - Otherwise, user_reinit_req → REQUEST.
  - Link loss wins over a coincident request; the request is dropped.
- REQUEST:
  - ack_s=1 → ACKED.
  - Otherwise, timer==ACK_TIMEOUT-1 → HOLDOFF, with ack_timeout_evt.
- ACKED: timer==ACK_TIMEOUT-1 → HOLDOFF, with ack_timeout_evt. This covers the case where the port stays initialized so the PHY reset never fires. Normal exit is the external reset_condition caused by the controller's PHY reset.
- HOLDOFF: timer==HOLDOFF_CYCLES-1 → WAIT_INIT.
- user_reinit_req is ignored in REQUEST, ACKED and HOLDOFF; there is no queuing.
- Outputs:
  - force_reinit = 1 exactly while state ∈ {REQUEST, ACKED}.
  - link_up = 1 exactly while state = LINK_UP.
  - Both are registered alongside the state, so they change on the same edge as the state.
- Event pulses are registered and last exactly one cycle on the transition edge.
- reset_condition mid-operation: everything returns to reset values immediately and asynchronously; the timer clears. This is the expected termination of every successful request.

## Timing
- Reset values: force_reinit=0, link_up=0, timeout_evt=0, link_down_evt=0, ack_timeout_evt=0, state=WAIT_INIT, timer=0.
- port_initialized rising (stable, in WAIT_INIT) → link_up high on the 3rd cfg_clk edge.
- Falling port_initialized → link_up low and link_down_evt high on the 3rd edge.
- controlled_force_reinit rising → state ACKED on the 3rd edge. force_reinit stays 1 throughout.
- Timeout: entering WAIT_INIT at edge E with pi_s=0 and monitor_en=1 → REQUEST, force_reinit=1 and timeout_evt at edge E+TIMEOUT_CYCLES.
- Abort: REQUEST entered at edge E without ack → force_reinit=0 at E+ACK_TIMEOUT, then WAIT_INIT at E+ACK_TIMEOUT+HOLDOFF_CYCLES.
- user_reinit_req sampled high at edge E in LINK_UP → force_reinit=1 after edge E.

## Test plan
- Reset, then port_initialized=1 → all outputs 0 during reset; link_up=1 on the 3rd edge after release; no events.
- TIMEOUT_CYCLES=16, monitor_en=1, port_initialized=0 → timeout_evt and force_reinit=1 at cycle 16. Ack asserted 5 cycles later → ACKED 3 edges later. Then pulse reset_condition → all outputs 0 asynchronously.
- LINK_UP, user_reinit_req one cycle, no ack, ACK_TIMEOUT=8, HOLDOFF_CYCLES=4 → force_reinit high exactly 8 cycles, ack_timeout_evt once, WAIT_INIT 4 cycles later, then LINK_UP.
- LINK_UP, port_initialized drops while user_reinit_req is held → link_down_evt, no force_reinit, state WAIT_INIT.
- monitor_en=0, port_initialized low for 100 cycles with TIMEOUT_CYCLES=16 → no timeout_evt. Raising monitor_en → timeout fires 16 cycles later.
- ACKED with port_initialized held high, ACK_TIMEOUT=8 → abort to HOLDOFF with force_reinit=0 on the 8th edge after entering ACKED.

Source files
------------

// File: rtl/srio_link_monitor_if.sv
// Signal bundle between the link monitor and its surroundings: PHY status,
// reset-controller handshake, software controls and status/event outputs.
interface srio_link_monitor_if;
    logic port_initialized;
    logic controlled_force_reinit;
    logic monitor_en;
    logic user_reinit_req;
    logic force_reinit;
    logic link_up;
    logic timeout_evt;
    logic link_down_evt;
    logic ack_timeout_evt;

    // The monitor side: consumes status/controls, drives request and events.
    modport master (
        input  port_initialized,
        input  controlled_force_reinit,
        input  monitor_en,
        input  user_reinit_req,
        output force_reinit,
        output link_up,
        output timeout_evt,
        output link_down_evt,
        output ack_timeout_evt
    );

    // The environment side: drives status/controls, observes the monitor.
    modport slave (
        output port_initialized,
        output controlled_force_reinit,
        output monitor_en,
        output user_reinit_req,
        input  force_reinit,
        input  link_up,
        input  timeout_evt,
        input  link_down_evt,
        input  ack_timeout_evt
    );
endinterface

// File: rtl/srio_link_monitor.sv
// SRIO link supervisor: requests a reinit from the reset controller when
// training times out or software asks, holds the request until acknowledged,
// and backs off if the resulting PHY reset never comes back to reset us.
module srio_link_monitor #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter logic [15:0] ACK_TIMEOUT    = 16'd4096,
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd1024
) (
    input  logic                   cfg_clk,
    input  logic                   reset_condition,
    srio_link_monitor_if.master    link
);

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        LINK_UP   = 3'd1,
        REQUEST   = 3'd2,
        ACKED     = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    // Terminal timer values: a transition fires on the edge after timer hits these.
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
    localparam logic [23:0] ACK_LAST     = {8'd0, ACK_TIMEOUT} - 24'd1;
    localparam logic [23:0] HOLDOFF_LAST = {8'd0, HOLDOFF_CYCLES} - 24'd1;

    // Bit 0: port_initialized, bit 1: controlled_force_reinit.
    logic [1:0] async_in;
    logic [1:0] sync_out;
    logic       pi_s;
    logic       ack_s;

    assign async_in = {link.controlled_force_reinit, link.port_initialized};
    assign pi_s     = sync_out[0];
    assign ack_s    = sync_out[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;

            // Two-flop synchronizer for an asynchronous status input.
            always_ff @(posedge cfg_clk or posedge reset_condition) begin
                if (reset_condition) begin
                    meta_reg <= 1'b0;
                    out_reg  <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    out_reg  <= meta_reg;
                end
            end

            assign sync_out[gi] = out_reg;
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [23:0] timer_reg, timer_next;
    logic        force_reinit_reg, force_reinit_next;
    logic        link_up_reg, link_up_next;
    logic        timeout_evt_reg, timeout_evt_next;
    logic        link_down_evt_reg, link_down_evt_next;
    logic        ack_timeout_evt_reg, ack_timeout_evt_next;

    // State, timer and registered outputs; outputs follow state_next so they
    // change on the same edge as the state itself.
    always_ff @(posedge cfg_clk or posedge reset_condition) begin
        if (reset_condition) begin
            state_reg           <= WAIT_INIT;
            timer_reg           <= 24'd0;
            force_reinit_reg    <= 1'b0;
            link_up_reg         <= 1'b0;
            timeout_evt_reg     <= 1'b0;
            link_down_evt_reg   <= 1'b0;
            ack_timeout_evt_reg <= 1'b0;
        end else begin
            state_reg           <= state_next;
            timer_reg           <= timer_next;
            force_reinit_reg    <= force_reinit_next;
            link_up_reg         <= link_up_next;
            timeout_evt_reg     <= timeout_evt_next;
            link_down_evt_reg   <= link_down_evt_next;
            ack_timeout_evt_reg <= ack_timeout_evt_next;
        end
    end

    // Next-state, timer and output decode.
    always_comb begin
        state_next           = state_reg;
        timeout_evt_next     = 1'b0;
        link_down_evt_next   = 1'b0;
        ack_timeout_evt_next = 1'b0;

        case (state_reg)
            WAIT_INIT: begin
                if (pi_s) begin
                    state_next = LINK_UP;
                end else begin
                    // A coincident software request still reports the timeout.
                    if (link.monitor_en && (timer_reg == TIMEOUT_LAST)) begin
                        state_next       = REQUEST;
                        timeout_evt_next = 1'b1;
                    end
                    if (link.user_reinit_req) begin
                        state_next = REQUEST;
                    end
                end
            end
            LINK_UP: begin
                // Link loss takes priority; a coincident request is dropped.
                if (!pi_s) begin
                    state_next         = WAIT_INIT;
                    link_down_evt_next = 1'b1;
                end else if (link.user_reinit_req) begin
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (ack_s) begin
                    state_next = ACKED;
                end else if (timer_reg == ACK_LAST) begin
                    state_next           = HOLDOFF;
                    ack_timeout_evt_next = 1'b1;
                end
            end
            ACKED: begin
                // Normally left via reset_condition; this catches a PHY reset
                // that never fires because the port stayed initialized.
                if (timer_reg == ACK_LAST) begin
                    state_next           = HOLDOFF;
                    ack_timeout_evt_next = 1'b1;
                end
            end
            HOLDOFF: begin
                if (timer_reg == HOLDOFF_LAST) begin
                    state_next = WAIT_INIT;
                end
            end
            default: begin
                state_next = WAIT_INIT;
            end
        endcase

        if (state_next != state_reg) begin
            timer_next = 24'd0;
        end else if (((state_reg == WAIT_INIT) && !link.monitor_en) ||
                     (state_reg == LINK_UP)) begin
            timer_next = 24'd0;
        end else begin
            timer_next = timer_reg + 24'd1;
        end

        force_reinit_next = (state_next == REQUEST) || (state_next == ACKED);
        link_up_next      = (state_next == LINK_UP);
    end

    assign link.force_reinit    = force_reinit_reg;
    assign link.link_up         = link_up_reg;
    assign link.timeout_evt     = timeout_evt_reg;
    assign link.link_down_evt   = link_down_evt_reg;
    assign link.ack_timeout_evt = ack_timeout_evt_reg;

endmodule

// File: tb/tb_srio_link_monitor.sv
// Directed bench for srio_link_monitor with short timeouts; expected output
// vectors are queued per step and compared once the DUT has clocked.
module tb_srio_link_monitor;

    logic cfg_clk = 1'b0;
    logic reset_condition;

    srio_link_monitor_if link_bus();

    srio_link_monitor #(
        .TIMEOUT_CYCLES (24'd16),
        .ACK_TIMEOUT    (16'd8),
        .HOLDOFF_CYCLES (16'd4)
    ) dut (
        .cfg_clk         (cfg_clk),
        .reset_condition (reset_condition),
        .link            (link_bus)
    );

    always #5 cfg_clk = ~cfg_clk;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_timeout = 0;
    int   n_link_down = 0;
    int   n_ack_timeout = 0;

    // Output vector: {force_reinit, link_up, timeout_evt, link_down_evt, ack_timeout_evt}
    function automatic logic [4:0] outs();
        return {link_bus.force_reinit, link_bus.link_up, link_bus.timeout_evt,
                link_bus.link_down_evt, link_bus.ack_timeout_evt};
    endfunction

    // Count event pulses in mid-cycle so each one-cycle pulse is seen once.
    always @(negedge cfg_clk) begin
        if (link_bus.timeout_evt === 1'b1)     n_timeout++;
        if (link_bus.link_down_evt === 1'b1)   n_link_down++;
        if (link_bus.ack_timeout_evt === 1'b1) n_ack_timeout++;
    end

    task automatic tick();
        @(posedge cfg_clk);
        #1;
    endtask

    task automatic check_front();
        exp_t       e;
        logic [4:0] obs;
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e   = sb_q.pop_front();
            obs = outs();
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
            $display("step %-14s out=%b", e.tag, obs);
        end
    endtask

    task automatic expect_step(input string tag, input logic [4:0] exp);
        sb_q.push_back('{tag, exp});
        tick();
        check_front();
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("count %-14s value=%0d", tag, obs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_condition                  = 1'b1;
        link_bus.port_initialized        = 1'b1;
        link_bus.controlled_force_reinit = 1'b0;
        link_bus.monitor_en              = 1'b0;
        link_bus.user_reinit_req         = 1'b0;

        // Outputs idle during reset, link comes up on the 3rd edge after release.
        for (int i = 0; i < 3; i++) expect_step("rst_hold", 5'b00000);
        reset_condition = 1'b0;
        expect_step("pi_up_e1", 5'b00000);
        expect_step("pi_up_e2", 5'b00000);
        expect_step("pi_up_e3", 5'b01000);
        expect_step("link_steady", 5'b01000);

        // Software request without ack: 8 cycles of force_reinit, abort, holdoff.
        link_bus.user_reinit_req = 1'b1;
        expect_step("req_enter", 5'b10000);
        link_bus.user_reinit_req = 1'b0;
        for (int i = 0; i < 7; i++) expect_step("req_wait", 5'b10000);
        expect_step("req_abort", 5'b00001);
        for (int i = 0; i < 4; i++) expect_step("holdoff", 5'b00000);
        expect_step("relink", 5'b01000);

        // Link loss coinciding with a request: loss wins, request dropped.
        link_bus.port_initialized = 1'b0;
        expect_step("loss_e1", 5'b01000);
        expect_step("loss_e2", 5'b01000);
        link_bus.user_reinit_req = 1'b1;
        expect_step("loss_e3", 5'b00010);
        link_bus.user_reinit_req = 1'b0;
        expect_step("loss_after", 5'b00000);

        // Timeout disabled, then enabled: fires 16 edges later.
        for (int i = 0; i < 100; i++) expect_step("mon_off", 5'b00000);
        link_bus.monitor_en = 1'b1;
        for (int i = 0; i < 15; i++) expect_step("mon_count", 5'b00000);
        expect_step("timeout_fire", 5'b10100);
        for (int i = 0; i < 4; i++) expect_step("req_pending", 5'b10000);

        // Ack arrives; ACKED restarts the timer so no abort at the REQUEST deadline.
        link_bus.controlled_force_reinit = 1'b1;
        for (int i = 0; i < 10; i++) expect_step("acked_hold", 5'b10000);

        // Asynchronous reset mid-cycle clears everything without a clock edge.
        reset_condition = 1'b1;
        #1;
        sb_q.push_back('{"async_reset", 5'b00000});
        check_front();
        link_bus.monitor_en              = 1'b0;
        link_bus.port_initialized        = 1'b1;
        link_bus.controlled_force_reinit = 1'b0;
        expect_step("rst2_hold", 5'b00000);
        reset_condition = 1'b0;
        expect_step("pi_up2_e1", 5'b00000);
        expect_step("pi_up2_e2", 5'b00000);
        expect_step("pi_up2_e3", 5'b01000);

        // ACKED but the port stays initialized: abort 8 edges after entering ACKED.
        link_bus.user_reinit_req = 1'b1;
        expect_step("req2_enter", 5'b10000);
        link_bus.user_reinit_req         = 1'b0;
        link_bus.controlled_force_reinit = 1'b1;
        for (int i = 0; i < 10; i++) expect_step("acked_wait", 5'b10000);
        expect_step("acked_abort", 5'b00001);
        link_bus.controlled_force_reinit = 1'b0;
        for (int i = 0; i < 4; i++) expect_step("holdoff2", 5'b00000);
        expect_step("relink2", 5'b01000);

        check_val("n_timeout", n_timeout, 1);
        check_val("n_link_down", n_link_down, 1);
        check_val("n_ack_timeout", n_ack_timeout, 2);
        check_val("sb_leftover", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
